// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave responder backed by a small byte-strobed register bank.
// Handles one outstanding write and one outstanding read. The write path
// has independent AW and W holding registers. The read path is a two-state
// FSM. Every output comes from a register.
// Optional feature macro: AXI4_LITE_SLAVE_MEM_RANGE_CHECK_EN. When it is
// defined, an address with any bit set above the bank gets SLVERR, its write
// is dropped and its read returns zero. When it is undefined, addresses alias
// modulo the bank size and every response is OKAY.
module axi4_lite_slave_mem #(
  parameter int data_width = 32,
  parameter int addr_width = 32,
  parameter int strb_width = data_width / 8,
  parameter int depth_log2 = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [addr_width-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [data_width-1:0] WDATA,
  input  logic [strb_width-1:0] WSTRB,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [addr_width-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [data_width-1:0] RDATA,
  output logic [1:0]            RRESP
);
  localparam int lsb   = $clog2(strb_width);
  localparam int words = 1 << depth_log2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  logic [data_width-1:0] mem [words];

  logic                  aw_full, w_full;
  logic [addr_width-1:0] aw_addr;
  logic [data_width-1:0] w_data;
  logic [strb_width-1:0] w_strb;
  logic [depth_log2-1:0] aw_idx, ar_idx;
  logic                  aw_oob, ar_oob;
  logic                  commit;
  rd_state_t             rd_state;

  assign aw_idx = aw_addr[lsb +: depth_log2];
  assign ar_idx = ARADDR[lsb +: depth_log2];

`ifdef AXI4_LITE_SLAVE_MEM_RANGE_CHECK_EN
  assign aw_oob = |(aw_addr >> (lsb + depth_log2));
  assign ar_oob = |(ARADDR >> (lsb + depth_log2));
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  // The protection bits and the address bits outside the word index are
  // deliberately ignored. Fold them here so the intent is visible.
  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, aw_addr, ARADDR};

  // A held write commits once both halves are present and the B slot is
  // free, or is being freed on this same edge.
  assign commit = aw_full && w_full && (!BVALID || BREADY);

  // Write path: AW/W capture, commit into the bank, and the B channel.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      for (int i = 0; i < words; i++) mem[i] <= '0;
    end else if (commit) begin
      // Both holding registers are full, so AWREADY and WREADY are low and
      // no new handshake can land on this edge.
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      AWREADY <= 1'b1;
      WREADY  <= 1'b1;
      BVALID  <= 1'b1;
      BRESP   <= aw_oob ? RESP_SLVERR : RESP_OKAY;
      if (!aw_oob) begin
        for (int i = 0; i < strb_width; i++)
          if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end else begin
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (AWVALID && AWREADY) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
        AWREADY <= 1'b0;
      end else begin
        AWREADY <= !aw_full;
      end
      if (WVALID && WREADY) begin
        w_full  <= 1'b1;
        w_data  <= WDATA;
        w_strb  <= WSTRB;
        WREADY  <= 1'b0;
      end else begin
        WREADY  <= !w_full;
      end
    end
  end

  // Read path FSM. On a same-edge commit, the bank read sees the pre-write
  // value because the bank write is non-blocking.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ARVALID && ARREADY) begin
            rd_state <= RD_RESP;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b1;
            RDATA    <= ar_oob ? '0 : mem[ar_idx];
            RRESP    <= ar_oob ? RESP_SLVERR : RESP_OKAY;
          end else begin
            ARREADY  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (RREADY) begin
            rd_state <= RD_IDLE;
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed bench for axi4_lite_slave_mem. Inputs are driven on the falling
// edge, and outputs are sampled on the falling edge.
module tb_axi4_lite_slave_mem;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_mem #(.data_width(32), .addr_width(32), .strb_width(4), .depth_log2(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  function automatic logic [31:0] strb_merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] s);
    logic [31:0] r = old_v;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Full write transaction. The caller is positioned just after a falling edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    bit aw_hs, w_hs;
    ok = 1'b1; resp = 2'bxx;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    for (int n = 0; n < 20 && (AWVALID || WVALID); n++) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs)  WVALID  = 1'b0;
    end
    if (AWVALID || WVALID) ok = 1'b0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (BVALID) begin
        resp = BRESP;
        @(posedge ACLK); @(negedge ACLK);
        BREADY = 1'b0;
        return;
      end
      @(posedge ACLK); @(negedge ACLK);
    end
    BREADY = 1'b0; ok = 1'b0;
  endtask

  // Full read transaction. The caller is positioned just after a falling edge.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output bit ok);
    bit got_ar = 1'b0;
    ok = 1'b0; d = 'x; resp = 2'bxx;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    for (int n = 0; n < 20 && !got_ar; n++) begin
      got_ar = ARREADY;
      @(posedge ACLK); @(negedge ACLK);
    end
    ARVALID = 1'b0;
    for (int n = 0; n < 20 && got_ar; n++) begin
      if (RVALID) begin
        d = RDATA; resp = RRESP; ok = 1'b1;
        @(posedge ACLK); @(negedge ACLK);
        RREADY = 1'b0;
        return;
      end
      @(posedge ACLK); @(negedge ACLK);
    end
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0 || RDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got rdy=%b%b%b vld=%b%b resp=%b/%b rdata=%h, want all zero",
                         AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA);
    end
    ARESET = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    n_checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      n_fail++; $display("FAIL reset_release: got aw/w/ar rdy b/r vld=%b, want 11100",
                         {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    axi_read(32'h0, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      n_fail++; $display("FAIL reset_read0: ok=%0b got %h/%b, want 00000000/00", ok, d, r);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r; bit ok;
    AWADDR = 32'h8; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    n_checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
      n_fail++; $display("FAIL wr_after_hs: got aw/w rdy,bvalid=%b, want 000", {AWREADY, WREADY, BVALID});
    end
    @(posedge ACLK); @(negedge ACLK);
    n_checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b111 || BRESP !== 2'b00) begin
      n_fail++; $display("FAIL wr_commit: got rdy/bvalid=%b bresp=%b, want 111/00", {AWREADY, WREADY, BVALID}, BRESP);
    end
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
    n_checks++;
    if (BVALID !== 1'b0) begin
      n_fail++; $display("FAIL wr_b_done: got bvalid=%b, want 0", BVALID);
    end
    axi_read(32'h8, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
      n_fail++; $display("FAIL wr_readback: ok=%0b got %h/%b, want deadbeef/00", ok, d, r);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(32'h8, 32'h11223344, 4'b0101, r, ok);
    n_checks++;
    if (!ok || r !== 2'b00) begin
      n_fail++; $display("FAIL strb_bresp: ok=%0b got %b, want 00", ok, r);
    end
    axi_read(32'h8, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'hDE22BE44 || d !== strb_merge(32'hDEADBEEF, 32'h11223344, 4'b0101)) begin
      n_fail++; $display("FAIL strb_readback: ok=%0b got %h, want de22be44", ok, d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; bit ok;
    BREADY = 1'b0;
    WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    WVALID = 1'b0;
    n_checks++;
    if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL bp_w_held: got wready=%b awready=%b, want 0/1", WREADY, AWREADY);
    end
    repeat (2) begin @(posedge ACLK); @(negedge ACLK); end
    AWADDR = 32'hC; AWVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    n_checks++;
    if (BVALID !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_early_b: got bvalid=%b, want 0", BVALID);
    end
    @(posedge ACLK); @(negedge ACLK);
    n_checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b111) begin
      n_fail++; $display("FAIL bp_first_commit: got bvalid/aw/w rdy=%b, want 111", {BVALID, AWREADY, WREADY});
    end
    AWADDR = 32'h4; WDATA = 32'h0BADF00D; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    repeat (2) begin
      @(posedge ACLK); @(negedge ACLK);
      n_checks++;
      if ({BVALID, AWREADY, WREADY} !== 3'b100 || BRESP !== 2'b00) begin
        n_fail++; $display("FAIL bp_stall: got bvalid/aw/w rdy=%b bresp=%b, want 100/00", {BVALID, AWREADY, WREADY}, BRESP);
      end
    end
    BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    n_checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b111) begin
      n_fail++; $display("FAIL bp_second_commit: got bvalid/aw/w rdy=%b, want 111", {BVALID, AWREADY, WREADY});
    end
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
    n_checks++;
    if (BVALID !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got bvalid=%b, want 0", BVALID);
    end
    axi_read(32'hC, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL bp_read_c: ok=%0b got %h, want a5a5a5a5", ok, d);
    end
    axi_read(32'h4, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL bp_read_4: ok=%0b got %h, want 0badf00d", ok, d);
    end
  endtask

  task automatic test_read_write_same_edge();
    logic [31:0] d; logic [1:0] r; bit ok;
    AWADDR = 32'h8; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    n_checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'hDE22BE44 || BVALID !== 1'b1) begin
      n_fail++; $display("FAIL same_edge_old: got rvalid=%b rdata=%h bvalid=%b, want 1/de22be44/1", RVALID, RDATA, BVALID);
    end
    RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0; BREADY = 1'b0;
    axi_read(32'h8, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL same_edge_new: ok=%0b got %h, want cafef00d", ok, d);
    end
  endtask

  task automatic test_back_to_back();
    ARADDR = 32'hC; ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    ARADDR = 32'h4;
    n_checks++;
    if (RVALID !== 1'b1 || ARREADY !== 1'b0 || RDATA !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL b2b_first: got rvalid=%b arready=%b rdata=%h, want 1/0/a5a5a5a5", RVALID, ARREADY, RDATA);
    end
    @(posedge ACLK); @(negedge ACLK);
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap: got rvalid=%b arready=%b, want 0/1", RVALID, ARREADY);
    end
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    n_checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL b2b_second: got rvalid=%b rdata=%h, want 1/0badf00d", RVALID, RDATA);
    end
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic test_range();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(32'h40, 32'h12345678, 4'hF, r, ok);
`ifdef AXI4_LITE_SLAVE_MEM_RANGE_CHECK_EN
    n_checks++;
    if (!ok || r !== 2'b10) begin n_fail++; $display("FAIL range_bresp: ok=%0b got %b, want 10", ok, r); end
    axi_read(32'h40, d, r, ok);
    n_checks++;
    if (!ok || r !== 2'b10 || d !== 32'h0) begin
      n_fail++; $display("FAIL range_read: ok=%0b got %h/%b, want 00000000/10", ok, d, r);
    end
    axi_read(32'h0, d, r, ok);
    n_checks++;
    if (!ok || r !== 2'b00 || d !== 32'h0) begin
      n_fail++; $display("FAIL range_dropped: ok=%0b got %h/%b, want 00000000/00", ok, d, r);
    end
`else
    n_checks++;
    if (!ok || r !== 2'b00) begin n_fail++; $display("FAIL range_bresp: ok=%0b got %b, want 00", ok, r); end
    axi_read(32'h40, d, r, ok);
    n_checks++;
    if (!ok || r !== 2'b00 || d !== 32'h12345678) begin
      n_fail++; $display("FAIL range_read: ok=%0b got %h/%b, want 12345678/00", ok, d, r);
    end
    axi_read(32'h0, d, r, ok);
    n_checks++;
    if (!ok || r !== 2'b00 || d !== 32'h12345678) begin
      n_fail++; $display("FAIL range_alias: ok=%0b got %h/%b, want 12345678/00", ok, d, r);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d; logic [1:0] r; bit ok;
    ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    n_checks++;
    if (RVALID !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got rvalid=%b, want 1", RVALID); end
    ARESET = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b0 || RDATA !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_rvalid: got rvalid=%b arready=%b rdata=%h, want 0/0/0", RVALID, ARREADY, RDATA);
    end
    ARESET = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    axi_read(32'h8, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_bank8: ok=%0b got %h/%b, want 00000000/00", ok, d, r);
    end
    axi_read(32'hC, d, r, ok);
    n_checks++;
    if (!ok || d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_bankc: ok=%0b got %h, want 0", ok, d); end
  endtask

  initial begin
    ARESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    AWADDR = '0; WDATA = '0; WSTRB = '0; ARADDR = '0; AWPROT = 3'b000; ARPROT = 3'b111;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_backpressure();
    test_read_write_same_edge();
    test_back_to_back();
    test_range();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
